// File: rtl/axi_resp_router.sv
`default_nettype none
// ============================================================================
// axi_resp_router
// Steers slave responses back to the granting master using an in-order
// tracking FIFO of encoded master indices (one entry per address handshake).
// Revision: 1.0
// ============================================================================
module axi_resp_router #(
  parameter int MST_NB = 3,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                       aclk,
  input  logic                       srst,
  input  logic [MST_NB-1:0]          req_grant,
  input  logic                       req_hs,
  output logic                       req_ready,
  input  logic                       s_resp_valid,
  output logic                       s_resp_ready,
  input  logic [DATA_W-1:0]          s_resp_data,
  input  logic                       s_resp_last,
  output logic [MST_NB-1:0]          m_resp_valid,
  input  logic [MST_NB-1:0]          m_resp_ready,
  output logic [DATA_W-1:0]          m_resp_data,
  output logic                       m_resp_last,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err
);

  localparam int IDX_W = $clog2(MST_NB);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [IDX_W-1:0] fifo_q [DEPTH];
  logic [IDX_W-1:0] fifo_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic             grant_onehot;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] head;
  logic             not_empty;
  logic             push;
  logic             pop;

  assign grant_onehot = (req_grant != '0) &&
                        ((req_grant & (req_grant - MST_NB'(1))) == '0);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < MST_NB; i++) begin
      if (req_grant[i]) grant_idx = IDX_W'(i);
    end
  end

  assign req_ready = (count_q != CNT_W'(DEPTH));
  assign not_empty = (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];

  // Routing depends only on registered FIFO state, never on req_*.
  always_comb begin
    m_resp_valid = '0;
    s_resp_ready = 1'b0;
    for (int i = 0; i < MST_NB; i++) begin
      if (not_empty && (head == IDX_W'(i))) begin
        m_resp_valid[i] = s_resp_valid;
        s_resp_ready    = m_resp_ready[i];
      end
    end
  end

  assign m_resp_data = s_resp_data;
  assign m_resp_last = s_resp_last;

  assign push = req_hs && req_ready && grant_onehot;
  assign pop  = s_resp_valid && s_resp_ready && s_resp_last;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q || (req_hs && (!req_ready || !grant_onehot));
    if (push) begin
      fifo_d[wr_ptr_q] = grant_idx;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign outstanding = count_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_resp_router.sv
`default_nettype none
// ============================================================================
// tb_axi_resp_router
// Directed self-checking bench for axi_resp_router (MST_NB=3, DEPTH=4).
// Revision: 1.0
// ============================================================================
module tb_axi_resp_router;

  localparam int MST_NB = 3;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;

  logic              aclk;
  logic              srst;
  logic [MST_NB-1:0] req_grant;
  logic              req_hs;
  logic              req_ready;
  logic              s_resp_valid;
  logic              s_resp_ready;
  logic [DATA_W-1:0] s_resp_data;
  logic              s_resp_last;
  logic [MST_NB-1:0] m_resp_valid;
  logic [MST_NB-1:0] m_resp_ready;
  logic [DATA_W-1:0] m_resp_data;
  logic              m_resp_last;
  logic [2:0]        outstanding;
  logic              err;

  int checks;
  int errors;

  axi_resp_router #(.MST_NB(MST_NB), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .aclk         (aclk),
    .srst         (srst),
    .req_grant    (req_grant),
    .req_hs       (req_hs),
    .req_ready    (req_ready),
    .s_resp_valid (s_resp_valid),
    .s_resp_ready (s_resp_ready),
    .s_resp_data  (s_resp_data),
    .s_resp_last  (s_resp_last),
    .m_resp_valid (m_resp_valid),
    .m_resp_ready (m_resp_ready),
    .m_resp_data  (m_resp_data),
    .m_resp_last  (m_resp_last),
    .outstanding  (outstanding),
    .err          (err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [MST_NB-1:0] g);
    req_hs    = 1'b1;
    req_grant = g;
    step();
    req_hs    = 1'b0;
    req_grant = '0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    step();
    step();
    srst = 1'b0;
    s_resp_valid = 1'b1;
    s_resp_last  = 1'b1;
    m_resp_ready = 3'b111;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    checks++; if (m_resp_valid !== 3'b000) begin errors++; $display("FAIL reset_m_valid got %b want 000", m_resp_valid); end
    checks++; if (s_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", s_resp_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    step();
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL empty_no_pop got %0d want 0", outstanding); end
    s_resp_valid = 1'b0;
  endtask

  task automatic test_in_order();
    logic [2:0] exp_v [3];
    logic [2:0] exp_o [3];
    exp_v = '{3'b001, 3'b100, 3'b010};
    exp_o = '{3'd2, 3'd1, 3'd0};
    push(3'b001);
    push(3'b100);
    push(3'b010);
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL inorder_fill got %0d want 3", outstanding); end
    s_resp_valid = 1'b1;
    s_resp_last  = 1'b1;
    m_resp_ready = 3'b111;
    for (int k = 0; k < 3; k++) begin
      s_resp_data = 8'hA0 + 8'(k);
      #1;
      checks++; if (m_resp_valid !== exp_v[k]) begin errors++; $display("FAIL inorder_valid%0d got %b want %b", k, m_resp_valid, exp_v[k]); end
      checks++; if (m_resp_data !== 8'hA0 + 8'(k)) begin errors++; $display("FAIL inorder_data%0d got %h want %h", k, m_resp_data, 8'hA0 + 8'(k)); end
      checks++; if (s_resp_ready !== 1'b1) begin errors++; $display("FAIL inorder_sready%0d got %b want 1", k, s_resp_ready); end
      step();
      checks++; if (outstanding !== exp_o[k]) begin errors++; $display("FAIL inorder_out%0d got %0d want %0d", k, outstanding, exp_o[k]); end
    end
    s_resp_valid = 1'b0;
  endtask

  task automatic test_burst();
    logic       rdy   [5];
    logic       last  [5];
    logic [2:0] exp_o [5];
    rdy   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    last  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_o = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    push(3'b010);
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL burst_fill got %0d want 1", outstanding); end
    s_resp_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      // Non-head readies driven opposite to prove they are ignored.
      m_resp_ready = {~rdy[c], rdy[c], ~rdy[c]};
      s_resp_last  = last[c];
      #1;
      checks++; if (m_resp_valid !== 3'b010) begin errors++; $display("FAIL burst_valid%0d got %b want 010", c, m_resp_valid); end
      checks++; if (s_resp_ready !== rdy[c]) begin errors++; $display("FAIL burst_sready%0d got %b want %b", c, s_resp_ready, rdy[c]); end
      checks++; if (m_resp_last !== last[c]) begin errors++; $display("FAIL burst_last%0d got %b want %b", c, m_resp_last, last[c]); end
      step();
      checks++; if (outstanding !== exp_o[c]) begin errors++; $display("FAIL burst_out%0d got %0d want %0d", c, outstanding, exp_o[c]); end
    end
    s_resp_valid = 1'b0;
    s_resp_last  = 1'b1;
    m_resp_ready = 3'b111;
  endtask

  task automatic test_full_wrap();
    int         q[$];
    logic [2:0] g;
    logic [2:0] want;
    push(3'b001); q.push_back(0);
    push(3'b010); q.push_back(1);
    push(3'b100); q.push_back(2);
    push(3'b001); q.push_back(0);
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_out got %0d want 4", outstanding); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", req_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err_pre got %b want 0", err); end
    push(3'b010);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL overflow_err got %b want 1", err); end
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL overflow_out got %0d want 4", outstanding); end
    s_resp_last  = 1'b1;
    m_resp_ready = 3'b111;
    for (int t = 0; t < 10; t++) begin
      s_resp_valid = 1'b1;
      s_resp_data  = 8'(t);
      want = 3'b001 << q[0];
      #1;
      checks++; if (m_resp_valid !== want) begin errors++; $display("FAIL wrap_valid%0d got %b want %b", t, m_resp_valid, want); end
      step();
      void'(q.pop_front());
      s_resp_valid = 1'b0;
      g = 3'b001 << (t % 3);
      push(g);
      q.push_back(t % 3);
      checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL wrap_out%0d got %0d want 4", t, outstanding); end
    end
    for (int t = 0; t < 4; t++) begin
      s_resp_valid = 1'b1;
      want = 3'b001 << q[0];
      #1;
      checks++; if (m_resp_valid !== want) begin errors++; $display("FAIL drain_valid%0d got %b want %b", t, m_resp_valid, want); end
      step();
      void'(q.pop_front());
    end
    s_resp_valid = 1'b0;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL drain_out got %0d want 0", outstanding); end
  endtask

  task automatic test_simul();
    push(3'b100);
    push(3'b001);
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL simul_fill got %0d want 2", outstanding); end
    s_resp_valid = 1'b1;
    s_resp_last  = 1'b1;
    m_resp_ready = 3'b111;
    req_hs       = 1'b1;
    req_grant    = 3'b010;
    #1;
    checks++; if (m_resp_valid !== 3'b100) begin errors++; $display("FAIL simul_head got %b want 100", m_resp_valid); end
    step();
    req_hs    = 1'b0;
    req_grant = '0;
    #1;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL simul_out got %0d want 2", outstanding); end
    checks++; if (m_resp_valid !== 3'b001) begin errors++; $display("FAIL simul_next got %b want 001", m_resp_valid); end
    step();
    checks++; if (m_resp_valid !== 3'b010) begin errors++; $display("FAIL simul_pushed got %b want 010", m_resp_valid); end
    step();
    s_resp_valid = 1'b0;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL simul_drain got %0d want 0", outstanding); end
  endtask

  task automatic test_bad_grant();
    srst = 1'b1;
    step();
    srst = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", err); end
    push(3'b001);
    push(3'b011);
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL multihot_out got %0d want 1", outstanding); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL multihot_err got %b want 1", err); end
    push(3'b000);
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL zerohot_out got %0d want 1", outstanding); end
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    s_resp_valid = 1'b1;
    #1;
    checks++; if (m_resp_valid !== 3'b001) begin errors++; $display("FAIL bad_head got %b want 001", m_resp_valid); end
    step();
    s_resp_valid = 1'b0;
    srst = 1'b1;
    step();
    srst = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_reset got %b want 0", err); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    srst         = 1'b1;
    req_grant    = '0;
    req_hs       = 1'b0;
    s_resp_valid = 1'b0;
    s_resp_data  = '0;
    s_resp_last  = 1'b1;
    m_resp_ready = '0;
    test_reset();
    test_in_order();
    test_burst();
    test_full_wrap();
    test_simul();
    test_bad_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
